// File: rtl/alu_seq_if.sv
// Request/response bundle between the controller and alu_seq.
// The master drives the operation request; the slave returns handshake, result and flags.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             START;
  logic [3:0]       OP;
  logic             CHAIN;
  logic [WIDTH-1:0] INPUTA;
  logic [WIDTH-1:0] INPUTB;
  logic             C_IN;
  logic             S_IN;
  logic             READY;
  logic             DONE;
  logic [WIDTH-1:0] OUT;
  logic [WIDTH-1:0] OUT_HI;
  logic             C_OUT;
  logic             S_OUT;
  logic             ZERO;

  modport master (
    output START, OP, CHAIN, INPUTA, INPUTB, C_IN, S_IN,
    input  READY, DONE, OUT, OUT_HI, C_OUT, S_OUT, ZERO
  );

  modport slave (
    input  START, OP, CHAIN, INPUTA, INPUTB, C_IN, S_IN,
    output READY, DONE, OUT, OUT_HI, C_OUT, S_OUT, ZERO
  );
endinterface

// File: rtl/alu_seq.sv
// Clocked ALU with persistent carry/shift flags for multi-word chains and an
// iterative shift-add unsigned multiplier. WIDTH must match the interface WIDTH.
module alu_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH) + 1
) (
  input  logic     CLK,
  input  logic     RESET,
  alu_seq_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SHL  = 4'd2;
  localparam logic [3:0] OP_SHR  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_PASS = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_CMP  = 4'd9;

  typedef enum logic {IDLE, MUL_RUN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] out_hi_q, out_hi_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d, s_q, s_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  logic             cin_c, sin_c;
  logic [WIDTH:0]   add_c, sub_c;
  logic [SHW-1:0]   n_c;
  logic [PW-1:0]    step1_c, step2_c;

  // One shift-add step; the add is WIDTH+1 wide so its carry lands in the top bit after the shift.
  function automatic logic [PW-1:0] mul_step(input logic [PW-1:0] p, input logic [WIDTH-1:0] m);
    logic [WIDTH:0] s;
    s = {1'b0, p[PW-1:WIDTH]} + (p[0] ? {1'b0, m} : (WIDTH+1)'(0));
    return {s, p[WIDTH-1:1]};
  endfunction

  always_comb begin
    cin_c   = bus.CHAIN ? c_q : bus.C_IN;
    sin_c   = bus.CHAIN ? s_q : bus.S_IN;
    add_c   = {1'b0, bus.INPUTA} + {1'b0, bus.INPUTB} + (WIDTH+1)'(cin_c);
    sub_c   = {1'b0, bus.INPUTA} + {1'b0, ~bus.INPUTB} + (WIDTH+1)'(cin_c);
    n_c     = bus.INPUTB[SHW-1:0];
    step1_c = mul_step(prod_q, mcand_q);
    step2_c = mul_step(step1_c, mcand_q);
  end

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    out_hi_d = out_hi_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    s_d      = s_q;
    zero_d   = zero_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.START) begin
          if (bus.OP == OP_MUL) begin
            state_d = MUL_RUN;
            cnt_d   = '0;
            prod_d  = {{WIDTH{1'b0}}, bus.INPUTB};
            mcand_d = bus.INPUTA;
          end else if (bus.OP == OP_CMP) begin
            done_d = 1'b1;
            c_d    = sub_c[WIDTH];
            zero_d = (sub_c[WIDTH-1:0] == '0);
          end else begin
            done_d   = 1'b1;
            out_hi_d = '0;
            c_d      = 1'b0;
            s_d      = 1'b0;
            case (bus.OP)
              OP_ADD:  {c_d, out_d} = add_c;
              OP_SUB:  {c_d, out_d} = sub_c;
              OP_SHL: begin
                if (n_c == SHW'(1)) begin
                  out_d = {bus.INPUTA[WIDTH-2:0], sin_c};
                  s_d   = bus.INPUTA[WIDTH-1];
                end else begin
                  out_d = bus.INPUTA << n_c;
                end
              end
              OP_SHR: begin
                if (n_c == SHW'(1)) begin
                  out_d = {sin_c, bus.INPUTA[WIDTH-1:1]};
                  s_d   = bus.INPUTA[0];
                end else begin
                  out_d = bus.INPUTA >> n_c;
                end
              end
              OP_XOR:  out_d = bus.INPUTA ^ bus.INPUTB;
              OP_AND:  out_d = bus.INPUTA & bus.INPUTB;
              OP_OR:   out_d = bus.INPUTA | bus.INPUTB;
              OP_PASS: out_d = bus.INPUTB;
              default: out_d = '0;
            endcase
            zero_d = (out_d == '0);
          end
        end
      end

      MUL_RUN: begin
        cnt_d = cnt_q + CW'(1);
        // The closing edge retires two steps so WIDTH steps fit in WIDTH-1 run edges.
        if (cnt_q == CW'(WIDTH - 2)) begin
          state_d  = IDLE;
          prod_d   = step2_c;
          out_d    = step2_c[WIDTH-1:0];
          out_hi_d = step2_c[PW-1:WIDTH];
          c_d      = |step2_c[PW-1:WIDTH];
          s_d      = 1'b0;
          zero_d   = (step2_c == '0);
          done_d   = 1'b1;
        end else begin
          prod_d = step1_c;
        end
      end

      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      out_q    <= '0;
      out_hi_q <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      s_q      <= 1'b0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      out_hi_q <= out_hi_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
      s_q      <= s_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.READY  = ready_q;
  assign bus.DONE   = done_q;
  assign bus.OUT    = out_q;
  assign bus.OUT_HI = out_hi_q;
  assign bus.C_OUT  = c_q;
  assign bus.S_OUT  = s_q;
  assign bus.ZERO   = zero_q;
endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq (WIDTH=8) against an arithmetic reference model.
module tb_alu_seq;
  localparam int unsigned W = 8;

  logic clk;
  logic rst;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq #(.WIDTH(W)) u_dut (.CLK(clk), .RESET(rst), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;
  int m_out, m_hi, m_c, m_s, m_zero;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".out"},    32'(bus.OUT),    32'(m_out));
    chk({tag, ".out_hi"}, 32'(bus.OUT_HI), 32'(m_hi));
    chk({tag, ".c_out"},  32'(bus.C_OUT),  32'(m_c));
    chk({tag, ".s_out"},  32'(bus.S_OUT),  32'(m_s));
    chk({tag, ".zero"},   32'(bus.ZERO),   32'(m_zero));
  endtask

  task automatic model_reset();
    m_out = 0; m_hi = 0; m_c = 0; m_s = 0; m_zero = 1;
  endtask

  // Reference behaviour from plain integer arithmetic.
  task automatic model(input int op, input int a, input int b, input int chain,
                       input int cin_i, input int sin_i);
    int cin, sin, n, d, p;
    cin = (chain != 0) ? m_c : cin_i;
    sin = (chain != 0) ? m_s : sin_i;
    n   = b % (2 * W);
    if (op == 9) begin
      d      = a - b + cin - 1;
      m_c    = (d >= 0) ? 1 : 0;
      m_zero = (((d + 256) % 256) == 0) ? 1 : 0;
      return;
    end
    m_hi = 0; m_c = 0; m_s = 0;
    case (op)
      0: begin p = a + b + cin; m_out = p % 256; m_c = p / 256; end
      1: begin d = a - b + cin - 1; m_out = (d + 256) % 256; m_c = (d >= 0) ? 1 : 0; end
      2: begin
        if (n == 1) begin m_out = (a * 2 + sin) % 256; m_s = a / 128; end
        else m_out = (n >= W) ? 0 : (a * (1 << n)) % 256;
      end
      3: begin
        if (n == 1) begin m_out = sin * 128 + a / 2; m_s = a % 2; end
        else m_out = (n >= W) ? 0 : a / (1 << n);
      end
      4: m_out = a ^ b;
      5: m_out = a & b;
      6: m_out = a | b;
      7: m_out = b;
      8: begin p = a * b; m_out = p % 256; m_hi = p / 256; m_c = (m_hi != 0) ? 1 : 0; end
      default: m_out = 0;
    endcase
    m_zero = (m_out == 0 && m_hi == 0) ? 1 : 0;
  endtask

  task automatic drive(input int op, input int a, input int b, input int chain,
                       input int cin, input int sin);
    bus.OP     = 4'(op);
    bus.INPUTA = 8'(a);
    bus.INPUTB = 8'(b);
    bus.CHAIN  = 1'(chain);
    bus.C_IN   = 1'(cin);
    bus.S_IN   = 1'(sin);
    bus.START  = 1'b1;
  endtask

  // Issue one op, wait for its completion (fixed latency), check DONE and results.
  task automatic run_op(input int op, input int a, input int b, input int chain,
                        input int cin, input int sin, input bit poke);
    drive(op, a, b, chain, cin, sin);
    model(op, a, b, chain, cin, sin);
    @(posedge clk); #1;
    bus.START = 1'b0;
    if (op == 8) begin
      for (int i = 0; i < int'(W) - 1; i++) begin
        chk("mul_busy.ready", 32'(bus.READY), 32'd0);
        chk("mul_busy.done",  32'(bus.DONE),  32'd0);
        if (poke && i == 2) begin
          bus.OP = 4'd0; bus.INPUTA = 8'h11; bus.START = 1'b1;
        end else begin
          bus.START = 1'b0;
        end
        @(posedge clk); #1;
      end
      bus.START = 1'b0;
    end
    chk("done",  32'(bus.DONE),  32'd1);
    chk("ready", 32'(bus.READY), 32'd1);
    check_outs("res");
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    chk("idle.done", 32'(bus.DONE), 32'd0);
    check_outs("hold");
  endtask

  initial begin
    rst = 1'b1;
    bus.START = 1'b0; bus.OP = 4'd0; bus.CHAIN = 1'b0;
    bus.INPUTA = '0; bus.INPUTB = '0; bus.C_IN = 1'b0; bus.S_IN = 1'b0;
    model_reset();
    #12;
    chk("rst.ready", 32'(bus.READY), 32'd1);
    chk("rst.done",  32'(bus.DONE),  32'd0);
    check_outs("rst");
    @(negedge clk);
    rst = 1'b0;

    // 16-bit chained add 0x01FF + 0x0001
    run_op(0, 'hFF, 'h01, 0, 0, 0, 0);
    run_op(0, 'h01, 'h00, 1, 0, 0, 0);
    run_op(1, 'h05, 'h07, 0, 1, 0, 0);
    run_op(9, 'h09, 'h09, 0, 1, 0, 0);
    run_op(2, 'h81, 1, 0, 0, 1, 0);
    run_op(3, 'hF0, 9, 0, 0, 0, 0);
    idle_cycle();
    run_op(8, 200, 3, 0, 0, 0, 1);
    idle_cycle();
    run_op(8, 'hFF, 'hFF, 0, 0, 0, 0);
    run_op(1, 'h10, 'h01, 1, 0, 0, 0);
    // back-to-back single-cycle ops
    run_op(4, 'h3C, 'h0F, 0, 0, 0, 0);
    run_op(5, 'h3C, 'h0F, 0, 0, 0, 0);
    run_op(7, 'h3C, 'h0F, 0, 0, 0, 0);
    run_op(12, 'h3C, 'h0F, 0, 0, 0, 0);
    idle_cycle();

    for (int k = 0; k < 250; k++) begin
      int op, b;
      op = int'($urandom_range(0, 15));
      b  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 17)) : int'($urandom_range(0, 255));
      run_op(op, int'($urandom_range(0, 255)), b, int'($urandom_range(0, 1)),
             int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    // Asynchronous reset in the middle of a multiply
    run_op(7, 0, 'hA5, 0, 0, 0, 0);
    run_op(0, 'hF0, 'h20, 0, 0, 0, 0);
    drive(8, 'hC3, 'h7D, 0, 0, 0);
    @(posedge clk); #1;
    bus.START = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("midrst.ready", 32'(bus.READY), 32'd1);
    chk("midrst.done",  32'(bus.DONE),  32'd0);
    check_outs("midrst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < int'(W) + 2; i++) begin
      @(posedge clk); #1;
      chk("postrst.done",  32'(bus.DONE),  32'd0);
      chk("postrst.ready", 32'(bus.READY), 32'd1);
    end
    check_outs("postrst");
    run_op(8, 13, 11, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
